// File: rtl/gnr_node_multi_pkg.sv
// Shared constants for the multi-copy network node: default geometry and the
// smallest legal per-copy update divisor.
package gnr_node_multi_pkg;

  localparam int unsigned DEF_WIDTH   = 1;
  localparam int unsigned DEF_NCOPIES = 2;
  localparam int unsigned DEF_DIVW    = 4;
  localparam int unsigned MIN_DIV     = 1;

endpackage

// File: rtl/gnr_node_copy.sv
// One independent node copy: state register, update divisor, step countdown
// and the one-cycle update strobe.
module gnr_node_copy
  import gnr_node_multi_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DIVW  = DEF_DIVW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             reset_nos_i,
  input  logic [WIDTH-1:0] init_state_i,
  input  logic [DIVW-1:0]  div_i,
  input  logic             start_s_i,
  input  logic [WIDTH-1:0] next_s_i,
  output logic [WIDTH-1:0] s_o,
  output logic             upd_o
);

  logic [WIDTH-1:0] s_q, s_d;
  logic [DIVW-1:0]  d_q, d_d;
  logic [DIVW-1:0]  c_q, c_d;
  logic             upd_q, upd_d;

  always_comb begin
    s_d   = s_q;
    d_d   = d_q;
    c_d   = c_q;
    upd_d = 1'b0;
    if (reset_nos_i) begin
      s_d = init_state_i;
      // A zero divisor would never reload the countdown sensibly; clamp it.
      d_d = (div_i == '0) ? DIVW'(MIN_DIV) : div_i;
      c_d = '0;
    end else if (start_i && start_s_i) begin
      if (c_q == '0) begin
        s_d   = next_s_i;
        c_d   = d_q - DIVW'(1);
        upd_d = 1'b1;
      end else begin
        c_d = c_q - DIVW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q   <= '0;
      d_q   <= DIVW'(MIN_DIV);
      c_q   <= '0;
      upd_q <= 1'b0;
    end else begin
      s_q   <= s_d;
      d_q   <= d_d;
      c_q   <= c_d;
      upd_q <= upd_d;
    end
  end

  assign s_o   = s_q;
  assign upd_o = upd_q;

endmodule

// File: rtl/gnr_node_multi.sv
// Array of independent node copies with a copy-0 / copy-1 equality flag,
// typically used for tortoise/hare cycle detection.
module gnr_node_multi
  import gnr_node_multi_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned NCOPIES = DEF_NCOPIES,
  parameter int unsigned DIVW    = DEF_DIVW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     reset_nos,
  input  logic [WIDTH-1:0]         init_state,
  input  logic [NCOPIES*DIVW-1:0]  div,
  input  logic [NCOPIES-1:0]       start_s,
  input  logic [NCOPIES*WIDTH-1:0] next_s,
  output logic [NCOPIES*WIDTH-1:0] s,
  output logic [NCOPIES-1:0]       upd,
  output logic                     eq01
);

  for (genvar k = 0; k < NCOPIES; k++) begin : g_copy
    gnr_node_copy #(
      .WIDTH (WIDTH),
      .DIVW  (DIVW)
    ) u_copy (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start),
      .reset_nos_i  (reset_nos),
      .init_state_i (init_state),
      .div_i        (div[k*DIVW +: DIVW]),
      .start_s_i    (start_s[k]),
      .next_s_i     (next_s[k*WIDTH +: WIDTH]),
      .s_o          (s[k*WIDTH +: WIDTH]),
      .upd_o        (upd[k])
    );
  end

  assign eq01 = (s[WIDTH-1:0] == s[2*WIDTH-1:WIDTH]);

endmodule

// File: tb/tb_gnr_node_multi.sv
// Self-checking bench for gnr_node_multi: directed table, corner sequences and
// randomized traffic against a step-count reference model.
module tb_gnr_node_multi;

  localparam int unsigned W  = 4;
  localparam int unsigned NC = 3;
  localparam int unsigned DW = 4;

  logic            clk, rst, start, reset_nos;
  logic [W-1:0]    init_state;
  logic [NC*DW-1:0] div;
  logic [NC-1:0]   start_s;
  logic [NC*W-1:0] next_s;
  logic [NC*W-1:0] s;
  logic [NC-1:0]   upd;
  logic            eq01;

  gnr_node_multi #(.WIDTH(W), .NCOPIES(NC), .DIVW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .reset_nos(reset_nos),
    .init_state(init_state), .div(div), .start_s(start_s),
    .next_s(next_s), .s(s), .upd(upd), .eq01(eq01)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: an update happens on every step whose index since the
  // last re-initialisation is a multiple of the stored divisor.
  logic [W-1:0] m_s   [NC];
  int unsigned  m_div [NC];
  int unsigned  m_nstep [NC];
  logic         m_upd [NC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else
      passed++;
  endtask

  task automatic model_rst();
    for (int k = 0; k < NC; k++) begin
      m_s[k] = '0; m_div[k] = 1; m_nstep[k] = 0; m_upd[k] = 1'b0;
    end
  endtask

  task automatic tick();
    logic [DW-1:0] dv;
    for (int k = 0; k < NC; k++) begin
      m_upd[k] = 1'b0;
      if (reset_nos) begin
        dv = div[k*DW +: DW];
        m_s[k] = init_state;
        m_div[k] = (dv == 0) ? 1 : int'(dv);
        m_nstep[k] = 0;
      end else if (start && start_s[k]) begin
        if (m_nstep[k] % m_div[k] == 0) begin
          m_s[k] = next_s[k*W +: W];
          m_upd[k] = 1'b1;
        end
        m_nstep[k]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cmp_model(input string tag);
    logic [NC*W-1:0] es;
    logic [NC-1:0]   eu;
    for (int k = 0; k < NC; k++) begin
      es[k*W +: W] = m_s[k];
      eu[k] = m_upd[k];
    end
    chk({tag, ".s"}, 32'(s), 32'(es));
    chk({tag, ".upd"}, 32'(upd), 32'(eu));
    chk({tag, ".eq01"}, 32'(eq01), 32'(m_s[0] == m_s[1]));
  endtask

  task automatic set_in(input logic st, input logic rn, input logic [W-1:0] ini,
                        input logic [NC*DW-1:0] dv, input logic [NC-1:0] ss,
                        input logic [NC*W-1:0] nx);
    start = st; reset_nos = rn; init_state = ini; div = dv; start_s = ss; next_s = nx;
  endtask

  typedef struct {
    logic            st;
    logic            rn;
    logic [W-1:0]    ini;
    logic [NC*DW-1:0] dv;
    logic [NC-1:0]   ss;
    logic [NC*W-1:0] nx;
    logic [NC*W-1:0] exp_s;
    logic [NC-1:0]   exp_u;
    logic            exp_eq;
  } vec_t;

  vec_t tbl[7];
  logic exp_u0[7];

  initial begin
    // Tortoise (copy 0, div 2) and hare (copy 1, div 1) with next = ~s.
    tbl[0] = '{1'b1, 1'b1, 4'h0, 12'h112, 3'b011, 12'h000, 12'h000, 3'b000, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 4'h0, 12'h112, 3'b011, 12'h0FF, 12'h0FF, 3'b011, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 4'h0, 12'h112, 3'b011, 12'h000, 12'h00F, 3'b010, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 4'h0, 12'h112, 3'b011, 12'h0F0, 12'h0F0, 3'b011, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 4'h0, 12'h112, 3'b011, 12'h00F, 12'h000, 3'b010, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 4'h0, 12'h112, 3'b011, 12'h0FF, 12'h0FF, 3'b011, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 4'h0, 12'h112, 3'b011, 12'h000, 12'h00F, 3'b010, 1'b0};
    exp_u0 = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    rst = 1'b1;
    set_in(1'b0, 1'b0, '0, '0, '0, '0);
    model_rst();
    #3;
    chk("rst.s", 32'(s), 32'h0);
    chk("rst.upd", 32'(upd), 32'h0);
    #9 rst = 1'b0;

    // Deassertion alone must not update; reset divisor is 1 so every step updates.
    tick(); cmp_model("post_rst_idle");
    set_in(1'b1, 1'b0, '0, '0, 3'b111, 12'h321);
    tick(); cmp_model("post_rst_step1");
    chk("post_rst_upd", 32'(upd), 32'h7);
    set_in(1'b1, 1'b0, '0, '0, 3'b111, 12'h654);
    tick(); cmp_model("post_rst_step2");

    for (int i = 0; i < 7; i++) begin
      set_in(tbl[i].st, tbl[i].rn, tbl[i].ini, tbl[i].dv, tbl[i].ss, tbl[i].nx);
      tick();
      chk($sformatf("tbl%0d.s", i), 32'(s), 32'(tbl[i].exp_s));
      chk($sformatf("tbl%0d.upd", i), 32'(upd), 32'(tbl[i].exp_u));
      chk($sformatf("tbl%0d.eq01", i), 32'(eq01), 32'(tbl[i].exp_eq));
    end

    // Zero divisor behaves as one.
    set_in(1'b1, 1'b1, 4'h0, 12'h110, 3'b000, '0);
    tick(); cmp_model("div0_init");
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 1'b0, '0, 12'h110, 3'b001, 12'(i + 1));
      tick();
      chk($sformatf("div0_upd%0d", i), 32'(upd[0]), 32'h1);
      chk($sformatf("div0_s%0d", i), 32'(s[W-1:0]), 32'(i + 1));
    end

    // Divisor 3: updates after steps 1, 4, 7 only.
    set_in(1'b1, 1'b1, 4'h0, 12'h113, 3'b000, '0);
    tick(); cmp_model("div3_init");
    for (int i = 0; i < 7; i++) begin
      set_in(1'b1, 1'b0, '0, 12'h000, 3'b001, 12'h005);
      tick();
      chk($sformatf("div3_upd%0d", i + 1), 32'(upd[0]), 32'(exp_u0[i]));
      chk($sformatf("div3_s%0d", i + 1), 32'(s[W-1:0]), 32'h5);
      cmp_model($sformatf("div3_m%0d", i + 1));
    end

    // reset_nos wins over simultaneous step requests.
    set_in(1'b1, 1'b1, 4'hA, 12'h111, 3'b111, 12'hBBB);
    tick();
    chk("prio.s", 32'(s), 32'hAAA);
    chk("prio.upd", 32'(upd), 32'h0);
    set_in(1'b1, 1'b0, 4'h0, 12'h000, 3'b111, 12'hBBB);
    tick();
    chk("prio_next.s", 32'(s), 32'hBBB);
    chk("prio_next.upd", 32'(upd), 32'h7);
    cmp_model("prio_m");

    // Asynchronous rst mid-countdown.
    set_in(1'b1, 1'b1, 4'h7, 12'h113, 3'b000, '0);
    tick();
    set_in(1'b1, 1'b0, '0, 12'h113, 3'b111, 12'h9C6);
    tick(); cmp_model("arst_step1");
    #2 rst = 1'b1;
    #1;
    chk("arst.s", 32'(s), 32'h0);
    chk("arst.upd", 32'(upd), 32'h0);
    rst = 1'b0;
    model_rst();
    set_in(1'b1, 1'b1, 4'h2, 12'h333, 3'b000, '0);
    tick(); cmp_model("arst_reinit");
    set_in(1'b1, 1'b0, '0, 12'h333, 3'b001, 12'h00E);
    tick();
    chk("arst_first.upd", 32'(upd[0]), 32'h1);
    cmp_model("arst_first");

    // start low freezes everything, including counters.
    set_in(1'b1, 1'b1, 4'h1, 12'h223, 3'b000, '0);
    tick();
    set_in(1'b1, 1'b0, '0, 12'h223, 3'b111, 12'h777);
    tick(); cmp_model("hold_pre");
    for (int i = 0; i < 5; i++) begin
      set_in(1'b0, 1'b0, '0, 12'hFFF, 3'b111, 12'hDDD);
      tick(); cmp_model($sformatf("hold%0d", i));
    end
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 1'b0, '0, 12'h000, 3'b111, 12'(i * 273 + 17));
      tick(); cmp_model($sformatf("hold_post%0d", i));
    end

    // Randomized traffic; div changes every cycle but only matters on reset_nos.
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0,
             W'($urandom), (NC*DW)'($urandom), NC'($urandom), (NC*W)'($urandom));
      tick(); cmp_model($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
